// File: rtl/pipe_pkg.sv
// Shared pipeline definitions.
//   pipe_state_t : skid-stage occupancy state (2'd3 is illegal and recovers to EMPTY)
//   *_W          : default payload widths for the named stage registers
//   PERF_CNT_W   : default width of per-stage performance counters
package pipe_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FULL  = 2'd1,
        ST_SKID  = 2'd2
    } pipe_state_t;

    localparam int unsigned IF_ID_W    = 64;
    localparam int unsigned ID_EX_W    = 118;
    localparam int unsigned EX_MEM_W   = 142;
    localparam int unsigned MEM_WB_W   = 104;
    localparam int unsigned PERF_CNT_W = 16;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter used for per-stage performance counters.
//   clk   : clock
//   reset : asynchronous active-high clear
//   inc   : count one event this cycle
//   count : current value, holds at all-ones
module sat_counter
    import pipe_pkg::*;
#(
    parameter int unsigned CNT_W = PERF_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/pipe_skid_reg_n.sv
// Pipeline stage register with valid/ready handshake and a two-entry skid
// buffer (main register M plus skid register S). in_ready comes straight
// from a flop, so there is no combinational path from out_ready/in_valid
// to in_ready.
//   clk, reset          : clock, asynchronous active-high reset
//   in, in_valid        : upstream payload / valid
//   in_ready            : stage can accept (registered)
//   out, out_valid      : downstream payload (BUBBLE when empty) / valid
//   out_ready           : downstream accepts
//   flush               : synchronous kill of all held entries
//   stall_cnt           : saturating count of out_valid & !out_ready cycles
module pipe_skid_reg_n
    import pipe_pkg::*;
#(
    parameter int unsigned      WIDTH  = EX_MEM_W,
    parameter logic [0:WIDTH-1] BUBBLE = '0,
    parameter int unsigned      CNT_W  = PERF_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [0:WIDTH-1] in,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [0:WIDTH-1] out,
    output logic             out_valid,
    input  logic             out_ready,
    input  logic             flush,
    output logic [CNT_W-1:0] stall_cnt
);

    pipe_state_t      state;
    logic [0:WIDTH-1] m_reg;
    logic [0:WIDTH-1] s_reg;
    logic             accept;
    logic             pop;

    assign out_valid = (state != ST_EMPTY);
    assign out       = out_valid ? m_reg : BUBBLE;
    assign accept    = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    // in_ready is updated alongside every transition into or out of SKID,
    // keeping it equal to (state != SKID) without decoding the state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ST_EMPTY;
            m_reg    <= BUBBLE;
            s_reg    <= BUBBLE;
            in_ready <= 1'b1;
        end else if (flush) begin
            state    <= ST_EMPTY;
            m_reg    <= BUBBLE;
            s_reg    <= BUBBLE;
            in_ready <= 1'b1;
        end else begin
            case (state)
                ST_EMPTY: begin
                    if (accept) begin
                        m_reg <= in;
                        state <= ST_FULL;
                    end
                end
                ST_FULL: begin
                    if (accept && pop) begin
                        m_reg <= in;
                    end else if (pop) begin
                        state <= ST_EMPTY;
                    end else if (accept) begin
                        s_reg    <= in;
                        state    <= ST_SKID;
                        in_ready <= 1'b0;
                    end
                end
                ST_SKID: begin
                    if (pop) begin
                        m_reg    <= s_reg;
                        state    <= ST_FULL;
                        in_ready <= 1'b1;
                    end
                end
                default: begin
                    state    <= ST_EMPTY;
                    m_reg    <= BUBBLE;
                    s_reg    <= BUBBLE;
                    in_ready <= 1'b1;
                end
            endcase
        end
    end

    sat_counter #(
        .CNT_W(CNT_W)
    ) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (out_valid & ~out_ready),
        .count (stall_cnt)
    );

endmodule

// File: tb/tb_pipe_skid_reg_n.sv
module tb_pipe_skid_reg_n;

    logic clk = 1'b0;
    logic reset;

    // main instance: WIDTH=142, CNT_W=4
    logic [0:141] din, dout;
    logic         in_valid, in_ready, out_valid, out_ready, flush;
    logic [3:0]   stall_cnt;

    // narrow instance: WIDTH=1, CNT_W=16, shares control inputs
    logic [0:0]   din1, dout1;
    logic         in_ready1, out_valid1;
    logic [15:0]  stall_cnt1;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pipe_skid_reg_n #(
        .WIDTH(142),
        .CNT_W(4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in        (din),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out       (dout),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .flush     (flush),
        .stall_cnt (stall_cnt)
    );

    pipe_skid_reg_n #(
        .WIDTH(1),
        .CNT_W(16)
    ) dut1 (
        .clk       (clk),
        .reset     (reset),
        .in        (din1),
        .in_valid  (in_valid),
        .in_ready  (in_ready1),
        .out       (dout1),
        .out_valid (out_valid1),
        .out_ready (out_ready),
        .flush     (flush),
        .stall_cnt (stall_cnt1)
    );

    task automatic check(input string name, input logic [141:0] act, input logic [141:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic         iv;
        logic [141:0] d;
        logic         ordy;
        logic         fl;
        logic         ev;
        logic [141:0] eo;
        logic         er;
        logic [3:0]   es;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(logic iv, logic [141:0] d, logic ordy, logic fl,
                                logic ev, logic [141:0] eo, logic er, logic [3:0] es);
        vecs.push_back('{iv, d, ordy, fl, ev, eo, er, es});
    endfunction

    task automatic drive(input logic iv, input logic [141:0] d, input logic ordy, input logic fl);
        in_valid  = iv;
        din       = d;
        out_ready = ordy;
        flush     = fl;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    localparam logic [141:0] P2A = 142'({18{8'h2A}});

    // reference model state for the random phase
    logic [141:0] q142[$];
    logic         q1[$];
    int unsigned  st4, st16;

    initial begin
        logic [141:0] rp;
        logic         rp1;
        logic         hold;
        logic         pop_m, acc_m;
        int unsigned  sz;

        reset = 1'b1;
        drive(1'b0, '0, 1'b0, 1'b0);
        din1 = '0;
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_out", dout, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_stall", stall_cnt, 0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        tick();

        // streaming 1..8
        for (int i = 1; i <= 8; i++) add(1, i, 1, 0, 1, i, 1, 0);
        add(0, 0, 1, 0, 0, 0, 1, 0);
        // back-pressure A, B, then C
        add(1, 'hA, 0, 0, 1, 'hA, 1, 0);
        add(1, 'hB, 0, 0, 1, 'hA, 0, 1);
        add(1, 'hC, 0, 0, 1, 'hA, 0, 2);
        add(1, 'hC, 1, 0, 1, 'hB, 1, 2);
        add(1, 'hC, 1, 0, 1, 'hC, 1, 2);
        add(0, 0,   1, 0, 0, 0,   1, 2);
        // flush while in SKID with 0x55 offered
        add(1, 'h11, 0, 0, 1, 'h11, 1, 2);
        add(1, 'h22, 0, 0, 1, 'h11, 0, 3);
        add(1, 'h55, 0, 1, 0, 0,    1, 4);
        add(0, 'h55, 1, 0, 0, 0,    1, 4);
        // flush with pop and accept in FULL, then flush with accept in EMPTY
        add(1, 'h66, 0, 0, 1, 'h66, 1, 4);
        add(1, 'h77, 1, 1, 0, 0,    1, 4);
        add(0, 0,    0, 0, 0, 0,    1, 4);
        add(1, 'h88, 0, 1, 0, 0,    1, 4);
        add(0, 0,    0, 0, 0, 0,    1, 4);

        foreach (vecs[i]) begin
            drive(vecs[i].iv, vecs[i].d, vecs[i].ordy, vecs[i].fl);
            tick();
            check($sformatf("v%0d_out_valid", i), out_valid, vecs[i].ev);
            check($sformatf("v%0d_out", i), dout, vecs[i].eo);
            check($sformatf("v%0d_in_ready", i), in_ready, vecs[i].er);
            check($sformatf("v%0d_stall", i), stall_cnt, vecs[i].es);
        end

        // stall counter saturation at CNT_W=4, starting from 4
        drive(1, 'h99, 0, 0);
        tick();
        check("sat_load_out", dout, 'h99);
        check("sat_load_stall", stall_cnt, 4);
        drive(0, 0, 0, 0);
        for (int i = 1; i <= 20; i++) begin
            tick();
            check($sformatf("sat_%0d", i), stall_cnt, (4 + i > 15) ? 15 : 4 + i);
            check($sformatf("sat_%0d_valid", i), out_valid, 1);
        end
        drive(0, 0, 0, 1);
        tick();
        check("sat_flush_valid", out_valid, 0);
        check("sat_flush_stall", stall_cnt, 15);
        drive(0, 0, 0, 0);
        tick();
        check("sat_after_stall", stall_cnt, 15);

        // asynchronous reset mid-stream while in SKID
        drive(1, P2A, 0, 0);
        tick();
        tick();
        check("pre_rst_in_ready", in_ready, 0);
        check("pre_rst_out", dout, P2A);
        #3;
        reset = 1'b1;
        #1;
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_out", dout, 0);
        check("mid_rst_in_ready", in_ready, 1);
        check("mid_rst_stall", stall_cnt, 0);
        check("mid_rst_valid_w1", out_valid1, 0);
        in_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        tick();
        check("post_rst_out_valid", out_valid, 0);

        // random traffic on both widths against a queue model
        st4 = 0;
        st16 = 0;
        hold = 1'b0;
        rp = '0;
        rp1 = 1'b0;
        for (int cyc = 0; cyc < 10000; cyc++) begin
            if (!hold) begin
                rp  = {$urandom(), $urandom(), $urandom(), $urandom(), 14'($urandom())};
                rp1 = 1'($urandom());
                in_valid = 1'($urandom());
            end
            din       = rp;
            din1      = rp1;
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 63) == 0);

            sz    = q142.size();
            pop_m = (sz > 0) && out_ready;
            acc_m = in_valid && (sz < 2);
            hold  = in_valid && !acc_m && !flush;
            if ((sz > 0) && !out_ready) begin
                if (st4 < 15) st4++;
                if (st16 < 65535) st16++;
            end
            if (flush) begin
                q142.delete();
                q1.delete();
            end else begin
                if (pop_m) begin
                    void'(q142.pop_front());
                    void'(q1.pop_front());
                end
                if (acc_m) begin
                    q142.push_back(rp);
                    q1.push_back(rp1);
                end
            end

            tick();
            sz = q142.size();
            check($sformatf("rnd%0d_valid", cyc), out_valid, sz > 0);
            check($sformatf("rnd%0d_ready", cyc), in_ready, sz < 2);
            check($sformatf("rnd%0d_out", cyc), dout, (sz > 0) ? q142[0] : '0);
            check($sformatf("rnd%0d_stall", cyc), stall_cnt, st4);
            check($sformatf("rnd%0d_valid_w1", cyc), out_valid1, sz > 0);
            check($sformatf("rnd%0d_ready_w1", cyc), in_ready1, sz < 2);
            check($sformatf("rnd%0d_out_w1", cyc), dout1, (sz > 0) ? q1[0] : 1'b0);
            check($sformatf("rnd%0d_stall_w1", cyc), stall_cnt1, st16);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
